// File: rtl/pulse_rx_pkg.sv
// Shared types and constants for the pulse link receiver.
// PULSE_LEN_DEF must match the transmitter's pulse width.
package pulse_rx_pkg;

   typedef enum logic [1:0] {
      ARM  = 2'd0,
      IDLE = 2'd1,
      MEAS = 2'd2
   } state_t;

   localparam int PULSE_LEN_DEF = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the pulse line. It is only built when PULSE_RX_SYNC_EN is defined.
// Both flops are cleared by the synchronous clr.
`ifdef PULSE_RX_SYNC_EN
module sync_2ff (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (clr) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`endif

// File: rtl/pulse_rx.sv
// Pulse line receiver: measures each high run of x and reports it as valid (length PULSE_LEN) or err.
// Define PULSE_RX_SYNC_EN to pass x through a two-flop synchronizer first, which adds 2 clocks of latency.
module pulse_rx
   import pulse_rx_pkg::*;
#(
   parameter int PULSE_LEN = PULSE_LEN_DEF,
   parameter int LEN_W     = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             x,
   output logic             valid,
   output logic             err,
   output logic             busy,
   output logic [LEN_W-1:0] last_len,
   output logic [CNT_W-1:0] pulse_cnt
);

   localparam logic [LEN_W-1:0] LEN_MAX = '1;
   localparam logic [LEN_W-1:0] LEN_TGT = LEN_W'(PULSE_LEN);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic x_s;

`ifdef PULSE_RX_SYNC_EN
   sync_2ff u_sync (
      .clk (clk),
      .clr (clr),
      .d   (x),
      .q   (x_s)
   );
`else
   assign x_s = x;
`endif

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len, len_nxt;
   logic             valid_nxt, err_nxt, busy_nxt;
   logic [LEN_W-1:0] last_len_nxt;
   logic [CNT_W-1:0] pulse_cnt_nxt;

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= ARM;
         len       <= '0;
         valid     <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         last_len  <= '0;
         pulse_cnt <= '0;
      end else begin
         state     <= state_nxt;
         len       <= len_nxt;
         valid     <= valid_nxt;
         err       <= err_nxt;
         busy      <= busy_nxt;
         last_len  <= last_len_nxt;
         pulse_cnt <= pulse_cnt_nxt;
      end
   end

   // ARM discards any run already in flight at reset by waiting for a low sample.
   always_comb begin
      state_nxt     = state;
      len_nxt       = len;
      valid_nxt     = 1'b0;
      err_nxt       = 1'b0;
      busy_nxt      = busy;
      last_len_nxt  = last_len;
      pulse_cnt_nxt = pulse_cnt;
      case (state)
         ARM: begin
            if (!x_s) state_nxt = IDLE;
         end
         IDLE: begin
            if (x_s) begin
               state_nxt = MEAS;
               len_nxt   = LEN_ONE;
               busy_nxt  = 1'b1;
            end
         end
         MEAS: begin
            if (x_s) begin
               if (len != LEN_MAX) len_nxt = len + LEN_ONE;
            end else begin
               state_nxt    = IDLE;
               busy_nxt     = 1'b0;
               last_len_nxt = len;
               if (len == LEN_TGT) begin
                  valid_nxt     = 1'b1;
                  pulse_cnt_nxt = pulse_cnt + CNT_ONE;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = ARM;
      endcase
   end

endmodule

// File: tb/tb_pulse_rx.sv
// Directed testbench for pulse_rx: one default instance and one with CNT_W=2 share the same stimulus.
// Expected strobe positions shift by 2 when PULSE_RX_SYNC_EN is defined.
module tb_pulse_rx;

`ifdef PULSE_RX_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       x   = 1'b0;

   logic       valid_a, err_a, busy_a;
   logic [3:0] last_len_a;
   logic [7:0] pulse_cnt_a;

   logic       valid_b, err_b, busy_b;
   logic [3:0] last_len_b;
   logic [1:0] pulse_cnt_b;

   int nCompared   = 0;
   int nMismatched = 0;

   int step, vCnt, vFirst, vLast, eCnt, eLast, bCnt, both;

   pulse_rx #(.PULSE_LEN(3), .LEN_W(4), .CNT_W(8)) dut_a (
      .clk       (clk),
      .clr       (clr),
      .x         (x),
      .valid     (valid_a),
      .err       (err_a),
      .busy      (busy_a),
      .last_len  (last_len_a),
      .pulse_cnt (pulse_cnt_a)
   );

   pulse_rx #(.PULSE_LEN(3), .LEN_W(4), .CNT_W(2)) dut_b (
      .clk       (clk),
      .clr       (clr),
      .x         (x),
      .valid     (valid_b),
      .err       (err_b),
      .busy      (busy_b),
      .last_len  (last_len_b),
      .pulse_cnt (pulse_cnt_b)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clearTally();
      step = 0; vCnt = 0; vFirst = -1; vLast = -1;
      eCnt = 0; eLast = -1; bCnt = 0; both = 0;
   endtask

   // Drive one sample, let it be clocked in, then tally the registered outputs of dut_a.
   task automatic applyStimulus(input logic xv);
      x = xv;
      @(posedge clk);
      #1;
      if (valid_a) begin
         vCnt++;
         if (vFirst < 0) vFirst = step;
         vLast = step;
      end
      if (err_a) begin
         eCnt++;
         eLast = step;
      end
      if (busy_a) bCnt++;
      if (valid_a && err_a) both++;
      step++;
   endtask

   task automatic applyZeros(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0);
   endtask

   task automatic doReset();
      clr = 1'b1;
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      clr = 1'b0;
      clearTally();
   endtask

   initial begin
      int cntB[5];
      cntB = '{1, 2, 3, 0, 1};

      // Single legal pulse
      doReset();
      checkOutput("rst_valid", valid_a, 0);
      checkOutput("rst_err", err_a, 0);
      checkOutput("rst_busy", busy_a, 0);
      checkOutput("rst_last_len", last_len_a, 0);
      checkOutput("rst_pulse_cnt", pulse_cnt_a, 0);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyZeros(LAT + 2);
      checkOutput("s1_valid_count", vCnt, 1);
      checkOutput("s1_valid_step", vFirst, 4 + LAT);
      checkOutput("s1_err_count", eCnt, 0);
      checkOutput("s1_busy_cycles", bCnt, 3);
      checkOutput("s1_last_len", last_len_a, 3);
      checkOutput("s1_pulse_cnt", pulse_cnt_a, 1);

      // Short then long runs
      doReset();
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyZeros(LAT + 1);
      checkOutput("s2_err_count_a", eCnt, 1);
      checkOutput("s2_err_step_a", eLast, 3 + LAT);
      checkOutput("s2_last_len_a", last_len_a, 2);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyZeros(LAT + 1);
      checkOutput("s2_err_count_b", eCnt, 2);
      checkOutput("s2_last_len_b", last_len_a, 4);
      checkOutput("s2_valid_count", vCnt, 0);
      checkOutput("s2_pulse_cnt", pulse_cnt_a, 0);

      // Back-to-back legal pulses separated by one low sample
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0);
         applyStimulus(1'b1);
         applyStimulus(1'b1);
         applyStimulus(1'b1);
      end
      applyZeros(LAT + 1);
      checkOutput("s3_valid_count", vCnt, 5);
      checkOutput("s3_first_step", vFirst, 4 + LAT);
      checkOutput("s3_last_step", vLast, 20 + LAT);
      checkOutput("s3_err_count", eCnt, 0);
      checkOutput("s3_pulse_cnt", pulse_cnt_a, 5);

`ifndef PULSE_RX_SYNC_EN
      // Reset in the middle of a run, line still high afterwards
      doReset();
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      clr = 1'b1;
      applyStimulus(1'b1);
      clr = 1'b0;
      clearTally();
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkOutput("s4_busy_in_arm", busy_a, 0);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyZeros(1);
      checkOutput("s4_valid_count", vCnt, 1);
      checkOutput("s4_valid_step", vFirst, 7);
      checkOutput("s4_err_count", eCnt, 0);
      checkOutput("s4_busy_cycles", bCnt, 3);
      checkOutput("s4_pulse_cnt", pulse_cnt_a, 1);
`endif

      // Stuck-high line saturates the length counter
      doReset();
      applyStimulus(1'b0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1);
      checkOutput("s5_no_strobe_while_high", vCnt + eCnt, 0);
      applyStimulus(1'b0);
      applyZeros(LAT + 1);
      checkOutput("s5_err_count", eCnt, 1);
      checkOutput("s5_err_step", eLast, 21 + LAT);
      checkOutput("s5_busy_cycles", bCnt, 20);
      checkOutput("s5_last_len", last_len_a, 15);
      checkOutput("s5_valid_count", vCnt, 0);

      // Narrow counter wraps; wide counter keeps counting
      doReset();
      applyStimulus(1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1);
         applyStimulus(1'b1);
         applyStimulus(1'b1);
         applyStimulus(1'b0);
         applyZeros(LAT);
         checkOutput($sformatf("s6_cnt_b_%0d", i), pulse_cnt_b, cntB[i]);
         checkOutput($sformatf("s6_cnt_a_%0d", i), pulse_cnt_a, i + 1);
      end

      checkOutput("valid_err_overlap", both, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
